// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID pipeline register with hazard stall, branch flush and external freeze.
// Optional perf counters for stall cycles and flushes are enabled by defining STALL_PERF_CNT_EN.
module fetch_stall_ctrl #(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_STALL = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               HazardIn,
    input  logic               BranchTakenIn,
    input  logic [PC_W-1:0]    BranchAddrIn,
    input  logic               FreezeIn,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [PC_W-1:0]    PCOut,
    output logic [PC_W-1:0]    IF_ID_PCOut,
    output logic [INSTR_W-1:0] IF_ID_InstrOut,
    output logic               IF_ID_ValidOut,
    output logic               ID_EX_BubbleOut,
    output logic               StallTimeoutOut,
    output logic [31:0]        StallCntOut,
    output logic [31:0]        FlushCntOut
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    // Run counter must be able to hold MAX_STALL+1, the value that trips the timeout.
    localparam int             RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL + 1);

    state_e             state_q,     state_d;
    logic [PC_W-1:0]    pc_q,        pc_d;
    logic [PC_W-1:0]    if_id_pc_q,  if_id_pc_d;
    logic [INSTR_W-1:0] if_id_ins_q, if_id_ins_d;
    logic               if_id_vld_q, if_id_vld_d;
    logic [RUN_W-1:0]   run_q,       run_d;
    logic               timeout_q,   timeout_d;
    logic [PC_W-1:0]    pc_plus4;

    assign pc_plus4 = pc_q + PC_W'(4);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        if_id_pc_d  = if_id_pc_q;
        if_id_ins_d = if_id_ins_q;
        if_id_vld_d = if_id_vld_q;
        run_d       = run_q;

        if (!FreezeIn) begin
            if (BranchTakenIn) begin
                pc_d        = BranchAddrIn;
                if_id_pc_d  = '0;
                if_id_ins_d = '0;
                if_id_vld_d = 1'b0;
                run_d       = '0;
                state_d     = ST_RUN;
            end else if (HazardIn) begin
                run_d   = (run_q == RUN_LIM) ? run_q : run_q + RUN_W'(1);
                state_d = ST_STALL;
            end else begin
                pc_d        = pc_plus4;
                if_id_pc_d  = pc_plus4;
                if_id_ins_d = InstrIn;
                if_id_vld_d = 1'b1;
                run_d       = '0;
                state_d     = ST_RUN;
            end
        end

        timeout_d = timeout_q | (run_d == RUN_LIM);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            state_q     <= ST_FILL;
            pc_q        <= RESET_PC;
            if_id_pc_q  <= '0;
            if_id_ins_q <= '0;
            if_id_vld_q <= 1'b0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_id_pc_q  <= if_id_pc_d;
            if_id_ins_q <= if_id_ins_d;
            if_id_vld_q <= if_id_vld_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PCOut           = pc_q;
    assign IF_ID_PCOut     = if_id_pc_q;
    assign IF_ID_InstrOut  = if_id_ins_q;
    assign IF_ID_ValidOut  = if_id_vld_q;
    assign StallTimeoutOut = timeout_q;
    assign ID_EX_BubbleOut = !FreezeIn && (BranchTakenIn || HazardIn || !if_id_vld_q);

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!FreezeIn) begin
            if (BranchTakenIn)
                flush_cnt_d = flush_cnt_q + 32'd1;
            else if (HazardIn)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCntOut = stall_cnt_q;
    assign FlushCntOut = flush_cnt_q;
`else
    assign StallCntOut = 32'd0;
    assign FlushCntOut = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: fetch sequencing, stall, flush, freeze, timeout, reset and PC wrap.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        HazardIn;
    logic        BranchTakenIn;
    logic [31:0] BranchAddrIn;
    logic        FreezeIn;
    logic [31:0] InstrIn;
    logic [31:0] PCOut;
    logic [31:0] IF_ID_PCOut;
    logic [31:0] IF_ID_InstrOut;
    logic        IF_ID_ValidOut;
    logic        ID_EX_BubbleOut;
    logic        StallTimeoutOut;
    logic [31:0] StallCntOut;
    logic [31:0] FlushCntOut;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    fetch_stall_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .HazardIn        (HazardIn),
        .BranchTakenIn   (BranchTakenIn),
        .BranchAddrIn    (BranchAddrIn),
        .FreezeIn        (FreezeIn),
        .InstrIn         (InstrIn),
        .PCOut           (PCOut),
        .IF_ID_PCOut     (IF_ID_PCOut),
        .IF_ID_InstrOut  (IF_ID_InstrOut),
        .IF_ID_ValidOut  (IF_ID_ValidOut),
        .ID_EX_BubbleOut (ID_EX_BubbleOut),
        .StallTimeoutOut (StallTimeoutOut),
        .StallCntOut     (StallCntOut),
        .FlushCntOut     (FlushCntOut)
    );

    always #5 clk = ~clk;

    // Counter model follows the inputs that are about to be sampled by the next edge.
    task automatic step();
        if (!rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else if (!FreezeIn) begin
            if (BranchTakenIn)  exp_flush++;
            else if (HazardIn)  exp_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_sc();
`ifdef STALL_PERF_CNT_EN
        return 32'(exp_stall);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_fc();
`ifdef STALL_PERF_CNT_EN
        return 32'(exp_flush);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle_inputs();
        HazardIn = 0; BranchTakenIn = 0; BranchAddrIn = 0; FreezeIn = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        InstrIn = 32'hFFFF_FFFF;
        rst = 0;
        step();
        step();
        n_cmp++; if (PCOut !== 32'h0)          begin n_bad++; $display("FAIL rst_pc: got %h want %h", PCOut, 32'h0); end
        n_cmp++; if (IF_ID_ValidOut !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b want 0", IF_ID_ValidOut); end
        n_cmp++; if (IF_ID_PCOut !== 32'h0)    begin n_bad++; $display("FAIL rst_ifid_pc: got %h want 0", IF_ID_PCOut); end
        n_cmp++; if (IF_ID_InstrOut !== 32'h0) begin n_bad++; $display("FAIL rst_ifid_instr: got %h want 0", IF_ID_InstrOut); end
        n_cmp++; if (StallTimeoutOut !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", StallTimeoutOut); end
        n_cmp++; if (StallCntOut !== 32'd0 || FlushCntOut !== 32'd0)
            begin n_bad++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", StallCntOut, FlushCntOut); end
        rst = 1;
    endtask

    task automatic test_fetch();
        InstrIn = 32'hE3A0_0001;
        n_cmp++; if (ID_EX_BubbleOut !== 1'b1) begin n_bad++; $display("FAIL fill_bubble: got %b want 1", ID_EX_BubbleOut); end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (PCOut !== 32'(4*k))       begin n_bad++; $display("FAIL fetch_pc%0d: got %h want %h", k, PCOut, 32'(4*k)); end
            n_cmp++; if (IF_ID_PCOut !== 32'(4*k)) begin n_bad++; $display("FAIL fetch_ifid_pc%0d: got %h want %h", k, IF_ID_PCOut, 32'(4*k)); end
            n_cmp++; if (IF_ID_ValidOut !== 1'b1 || IF_ID_InstrOut !== 32'hE3A0_0001)
                begin n_bad++; $display("FAIL fetch_ifid%0d: got %b/%h want 1/e3a00001", k, IF_ID_ValidOut, IF_ID_InstrOut); end
            n_cmp++; if (ID_EX_BubbleOut !== 1'b0) begin n_bad++; $display("FAIL fetch_bubble%0d: got %b want 0", k, ID_EX_BubbleOut); end
        end
    endtask

    task automatic test_hazard();
        do_reset();
        InstrIn = 32'h0000_0100; step();
        InstrIn = 32'h0000_0104; step();
        HazardIn = 1; InstrIn = 32'hDEAD_0008;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (ID_EX_BubbleOut !== 1'b1) begin n_bad++; $display("FAIL hz_bubble%0d: got %b want 1", k, ID_EX_BubbleOut); end
            step();
            n_cmp++; if (PCOut !== 32'h8 || IF_ID_PCOut !== 32'h8 || IF_ID_InstrOut !== 32'h0000_0104)
                begin n_bad++; $display("FAIL hz_hold%0d: got pc %h ifid %h/%h want 8 8/104", k, PCOut, IF_ID_PCOut, IF_ID_InstrOut); end
        end
        HazardIn = 0;
        #1;
        n_cmp++; if (ID_EX_BubbleOut !== 1'b0) begin n_bad++; $display("FAIL hz_release_bubble: got %b want 0", ID_EX_BubbleOut); end
        step();
        n_cmp++; if (PCOut !== 32'hC || IF_ID_PCOut !== 32'hC || IF_ID_InstrOut !== 32'hDEAD_0008)
            begin n_bad++; $display("FAIL hz_release: got pc %h ifid %h/%h want c c/dead0008", PCOut, IF_ID_PCOut, IF_ID_InstrOut); end
        n_cmp++; if (StallCntOut !== exp_sc()) begin n_bad++; $display("FAIL hz_stallcnt: got %0d want %0d", StallCntOut, exp_sc()); end
    endtask

    task automatic test_branch();
        HazardIn = 1; BranchTakenIn = 1; BranchAddrIn = 32'h40;
        #1;
        n_cmp++; if (ID_EX_BubbleOut !== 1'b1) begin n_bad++; $display("FAIL br_bubble: got %b want 1", ID_EX_BubbleOut); end
        step();
        idle_inputs();
        InstrIn = 32'h1234_5678;
        #1;
        n_cmp++; if (PCOut !== 32'h40) begin n_bad++; $display("FAIL br_pc: got %h want 40", PCOut); end
        n_cmp++; if (IF_ID_ValidOut !== 1'b0 || IF_ID_PCOut !== 32'h0 || IF_ID_InstrOut !== 32'h0)
            begin n_bad++; $display("FAIL br_flush: got %b %h %h want 0 0 0", IF_ID_ValidOut, IF_ID_PCOut, IF_ID_InstrOut); end
        n_cmp++; if (ID_EX_BubbleOut !== 1'b1) begin n_bad++; $display("FAIL br_post_bubble: got %b want 1", ID_EX_BubbleOut); end
        n_cmp++; if (FlushCntOut !== exp_fc() || StallCntOut !== exp_sc())
            begin n_bad++; $display("FAIL br_cnts: got %0d/%0d want %0d/%0d", FlushCntOut, StallCntOut, exp_fc(), exp_sc()); end
        // Branch must have left the FSM in RUN: a plain cycle resumes fetching.
        step();
        n_cmp++; if (PCOut !== 32'h44 || IF_ID_PCOut !== 32'h44 || IF_ID_ValidOut !== 1'b1 || ID_EX_BubbleOut !== 1'b0)
            begin n_bad++; $display("FAIL br_resume: got pc %h ifid %h v %b b %b want 44 44 1 0", PCOut, IF_ID_PCOut, IF_ID_ValidOut, ID_EX_BubbleOut); end
    endtask

    task automatic test_freeze();
        FreezeIn = 1; HazardIn = 1; InstrIn = 32'hFFFF_0000;
        #1;
        n_cmp++; if (ID_EX_BubbleOut !== 1'b0) begin n_bad++; $display("FAIL frz_bubble: got %b want 0", ID_EX_BubbleOut); end
        step(); step();
        n_cmp++; if (PCOut !== 32'h44 || IF_ID_PCOut !== 32'h44 || IF_ID_InstrOut !== 32'h1234_5678)
            begin n_bad++; $display("FAIL frz_hold: got pc %h ifid %h/%h want 44 44/12345678", PCOut, IF_ID_PCOut, IF_ID_InstrOut); end
        n_cmp++; if (StallCntOut !== exp_sc()) begin n_bad++; $display("FAIL frz_stallcnt: got %0d want %0d", StallCntOut, exp_sc()); end
        HazardIn = 0; BranchTakenIn = 1; BranchAddrIn = 32'h80;
        #1;
        n_cmp++; if (ID_EX_BubbleOut !== 1'b0) begin n_bad++; $display("FAIL frz_br_bubble: got %b want 0", ID_EX_BubbleOut); end
        step();
        n_cmp++; if (PCOut !== 32'h44 || IF_ID_ValidOut !== 1'b1 || FlushCntOut !== exp_fc())
            begin n_bad++; $display("FAIL frz_br_hold: got pc %h v %b fc %0d want 44 1 %0d", PCOut, IF_ID_ValidOut, FlushCntOut, exp_fc()); end
        idle_inputs();
        step();
        n_cmp++; if (PCOut !== 32'h48 || IF_ID_InstrOut !== 32'hFFFF_0000)
            begin n_bad++; $display("FAIL frz_release: got pc %h instr %h want 48 ffff0000", PCOut, IF_ID_InstrOut); end
    endtask

    task automatic test_timeout();
        do_reset();
        HazardIn = 1;
        for (int k = 0; k < 15; k++) step();
        n_cmp++; if (StallTimeoutOut !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", StallTimeoutOut); end
        step();
        n_cmp++; if (StallTimeoutOut !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b want 1", StallTimeoutOut); end
        n_cmp++; if (PCOut !== 32'h0) begin n_bad++; $display("FAIL to_pc_hold: got %h want 0", PCOut); end
        HazardIn = 0;
        step();
        n_cmp++; if (StallTimeoutOut !== 1'b1 || PCOut !== 32'h4)
            begin n_bad++; $display("FAIL to_sticky: got %b pc %h want 1 4", StallTimeoutOut, PCOut); end
        n_cmp++; if (StallCntOut !== exp_sc()) begin n_bad++; $display("FAIL to_stallcnt: got %0d want %0d", StallCntOut, exp_sc()); end
        rst = 0;
        step();
        rst = 1;
        n_cmp++; if (StallTimeoutOut !== 1'b0) begin n_bad++; $display("FAIL to_rst_clear: got %b want 0", StallTimeoutOut); end
    endtask

    task automatic test_run_length();
        // A single normal cycle between stall runs resets the run length.
        do_reset();
        HazardIn = 1;
        for (int k = 0; k < 15; k++) step();
        HazardIn = 0; step();
        HazardIn = 1; step();
        n_cmp++; if (StallTimeoutOut !== 1'b0) begin n_bad++; $display("FAIL run_clear: got %b want 0", StallTimeoutOut); end
        // Freeze cycles neither advance nor clear the run length.
        do_reset();
        HazardIn = 1;
        for (int k = 0; k < 10; k++) step();
        FreezeIn = 1;
        for (int k = 0; k < 3; k++) step();
        FreezeIn = 0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (StallTimeoutOut !== 1'b0) begin n_bad++; $display("FAIL run_frz_early: got %b want 0", StallTimeoutOut); end
        step();
        n_cmp++; if (StallTimeoutOut !== 1'b1) begin n_bad++; $display("FAIL run_frz_hold: got %b want 1", StallTimeoutOut); end
        HazardIn = 0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        BranchTakenIn = 1; BranchAddrIn = 32'h20;
        step();
        BranchTakenIn = 0; HazardIn = 1;
        step();
        n_cmp++; if (PCOut !== 32'h20) begin n_bad++; $display("FAIL rms_setup: got %h want 20", PCOut); end
        rst = 0; BranchTakenIn = 1; BranchAddrIn = 32'h60;
        step();
        rst = 1; idle_inputs();
        #1;
        n_cmp++; if (PCOut !== 32'h0 || IF_ID_ValidOut !== 1'b0 || IF_ID_PCOut !== 32'h0)
            begin n_bad++; $display("FAIL rms_state: got pc %h v %b ifid %h want 0 0 0", PCOut, IF_ID_ValidOut, IF_ID_PCOut); end
        n_cmp++; if (StallCntOut !== 32'd0 || FlushCntOut !== 32'd0)
            begin n_bad++; $display("FAIL rms_cnts: got %0d/%0d want 0/0", StallCntOut, FlushCntOut); end
        n_cmp++; if (ID_EX_BubbleOut !== 1'b1) begin n_bad++; $display("FAIL rms_fill_bubble: got %b want 1", ID_EX_BubbleOut); end
        step();
        n_cmp++; if (PCOut !== 32'h4 || ID_EX_BubbleOut !== 1'b0)
            begin n_bad++; $display("FAIL rms_resume: got pc %h b %b want 4 0", PCOut, ID_EX_BubbleOut); end
    endtask

    task automatic test_wrap();
        BranchTakenIn = 1; BranchAddrIn = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        InstrIn = 32'hCAFE_F00D;
        n_cmp++; if (PCOut !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target: got %h want fffffffc", PCOut); end
        step();
        n_cmp++; if (PCOut !== 32'h0 || IF_ID_PCOut !== 32'h0 || IF_ID_ValidOut !== 1'b1 || IF_ID_InstrOut !== 32'hCAFE_F00D)
            begin n_bad++; $display("FAIL wrap_pc: got pc %h ifid %h v %b i %h want 0 0 1 cafef00d", PCOut, IF_ID_PCOut, IF_ID_ValidOut, IF_ID_InstrOut); end
        n_cmp++; if (FlushCntOut !== exp_fc()) begin n_bad++; $display("FAIL wrap_flushcnt: got %0d want %0d", FlushCntOut, exp_fc()); end
    endtask

    initial begin
        rst = 0;
        InstrIn = 0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_hazard();
        test_branch();
        test_freeze();
        test_timeout();
        test_run_length();
        test_reset_mid_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
